// File: rtl/acc_requant_buffer.sv
// acc_requant_buffer
//   Accumulator buffer between the systolic array output and the unified
//   buffer. Entries hold DATA_NUM signed partial sums that are either
//   overwritten or accumulated with saturation. Reads go through a 2-stage
//   registered pipeline that requantises each lane (arithmetic right shift,
//   round-half-up, clamp to OUTPUT_DATA_SIZE) and emits lanes in reversed order.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   wea, acc_en       : write strobe; 1 = accumulate, 0 = overwrite
//   addra, dina       : write address / data (lane i at dina[i*DATA_SIZE +: DATA_SIZE])
//   enb, addrb        : read strobe / address
//   shift, clr_on_rd  : requant shift and invalidate-on-read, sampled with enb
//   ovf_clr           : clears acc_ovf (a same-cycle overflow wins)
//   doutb             : requantised word, lane i at the reversed position
//   doutb_valid       : one-cycle strobe when doutb carries a new result
//   acc_ovf           : sticky accumulate saturation flag
module acc_requant_buffer #(
  parameter int DATA_SIZE        = 20,
  parameter int OUTPUT_DATA_SIZE = 8,
  parameter int DATA_NUM         = 16,
  parameter int RAM_DEPTH        = 64,
  parameter int SHIFT_WIDTH      = 5,
  parameter int ADDR_WIDTH       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wea,
  input  logic                                 acc_en,
  input  logic [ADDR_WIDTH-1:0]                addra,
  input  logic [DATA_NUM*DATA_SIZE-1:0]        dina,
  input  logic                                 enb,
  input  logic [ADDR_WIDTH-1:0]                addrb,
  input  logic [SHIFT_WIDTH-1:0]               shift,
  input  logic                                 clr_on_rd,
  input  logic                                 ovf_clr,
  output logic [DATA_NUM*OUTPUT_DATA_SIZE-1:0] doutb,
  output logic                                 doutb_valid,
  output logic                                 acc_ovf
);

  localparam int WORD_W  = DATA_NUM * DATA_SIZE;
  localparam int OWORD_W = DATA_NUM * OUTPUT_DATA_SIZE;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic signed [DATA_SIZE:0] ACC_MAX = (DATA_SIZE+1)'((2**(DATA_SIZE-1)) - 1);
  localparam logic signed [DATA_SIZE:0] ACC_MIN = (DATA_SIZE+1)'(-(2**(DATA_SIZE-1)));
  localparam logic signed [DATA_SIZE:0] OUT_MAX = (DATA_SIZE+1)'((2**(OUTPUT_DATA_SIZE-1)) - 1);
  localparam logic signed [DATA_SIZE:0] OUT_MIN = (DATA_SIZE+1)'(-(2**(OUTPUT_DATA_SIZE-1)));

  function automatic logic signed [DATA_SIZE-1:0] sat_acc(input logic signed [DATA_SIZE:0] x);
    if (x > ACC_MAX)      return ACC_MAX[DATA_SIZE-1:0];
    else if (x < ACC_MIN) return ACC_MIN[DATA_SIZE-1:0];
    else                  return x[DATA_SIZE-1:0];
  endfunction

  // The extra bit keeps v + 2^(s-1) from wrapping before the shift.
  function automatic logic signed [OUTPUT_DATA_SIZE-1:0] requant(
    input logic signed [DATA_SIZE-1:0] v,
    input logic [SHIFT_WIDTH-1:0]      s
  );
    logic signed [DATA_SIZE:0] ext;
    logic signed [DATA_SIZE:0] half;
    logic signed [DATA_SIZE:0] r;
    ext  = (DATA_SIZE+1)'(v);
    half = '0;
    r    = ext;
    if (s != '0) begin
      half = (DATA_SIZE+1)'(1) << (s - 1'b1);
      r    = (ext + half) >>> s;
    end
    if (r > OUT_MAX)      return OUT_MAX[OUTPUT_DATA_SIZE-1:0];
    else if (r < OUT_MIN) return OUT_MIN[OUTPUT_DATA_SIZE-1:0];
    else                  return r[OUTPUT_DATA_SIZE-1:0];
  endfunction

  logic [WORD_W-1:0]      mem_q [RAM_DEPTH];
  logic [RAM_DEPTH-1:0]   valid_q, valid_d;
  logic                   acc_ovf_q, acc_ovf_d;
  logic [WORD_W-1:0]      word_p1_q, word_p1_d;
  logic [SHIFT_WIDTH-1:0] shift_p1_q, shift_p1_d;
  logic                   vld_p1_q, vld_p1_d;
  logic [OWORD_W-1:0]     doutb_q, doutb_d;
  logic                   doutb_valid_q, doutb_valid_d;

  logic                   wr_ok, rd_ok, ovf_any;
  logic [WORD_W-1:0]      old_word, wr_word;

  // Write path: effective old value, saturating accumulate, valid/flag update
  always_comb begin
    logic signed [DATA_SIZE-1:0] old_l;
    logic signed [DATA_SIZE-1:0] din_l;
    logic signed [DATA_SIZE:0]   sum_l;
    wr_ok    = ({1'b0, addra} < DEPTH_L);
    rd_ok    = ({1'b0, addrb} < DEPTH_L);
    old_word = (wr_ok && valid_q[addra]) ? mem_q[addra] : '0;
    wr_word  = dina;
    ovf_any  = 1'b0;
    old_l    = '0;
    din_l    = '0;
    sum_l    = '0;
    if (acc_en) begin
      for (int i = 0; i < DATA_NUM; i++) begin
        old_l = old_word[i*DATA_SIZE +: DATA_SIZE];
        din_l = dina[i*DATA_SIZE +: DATA_SIZE];
        sum_l = (DATA_SIZE+1)'(old_l) + (DATA_SIZE+1)'(din_l);
        wr_word[i*DATA_SIZE +: DATA_SIZE] = sat_acc(sum_l);
        // Top two bits differ exactly when the sum left the DATA_SIZE range.
        if (sum_l[DATA_SIZE] != sum_l[DATA_SIZE-1]) ovf_any = 1'b1;
      end
    end

    valid_d = valid_q;
    if (enb && clr_on_rd && rd_ok) valid_d[addrb] = 1'b0;
    // Applied after the clear so a same-address write keeps the entry valid.
    if (wea && wr_ok) valid_d[addra] = 1'b1;

    acc_ovf_d = acc_ovf_q;
    if (wea && wr_ok && acc_en && ovf_any) acc_ovf_d = 1'b1;
    else if (ovf_clr)                      acc_ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wea && wr_ok) mem_q[addra] <= wr_word;
  end

  // Stage 1: capture effective word and clamped shift
  always_comb begin
    vld_p1_d   = enb;
    word_p1_d  = word_p1_q;
    shift_p1_d = shift_p1_q;
    if (enb) begin
      word_p1_d  = (rd_ok && valid_q[addrb]) ? mem_q[addrb] : '0;
      shift_p1_d = (int'(shift) > DATA_SIZE - 1) ? SHIFT_WIDTH'(DATA_SIZE - 1) : shift;
    end
  end

  // Stage 2: requantise and reverse lane order
  always_comb begin
    doutb_valid_d = vld_p1_q;
    doutb_d       = doutb_q;
    if (vld_p1_q) begin
      for (int i = 0; i < DATA_NUM; i++) begin
        doutb_d[(DATA_NUM-1-i)*OUTPUT_DATA_SIZE +: OUTPUT_DATA_SIZE] =
          requant(word_p1_q[i*DATA_SIZE +: DATA_SIZE], shift_p1_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      acc_ovf_q     <= 1'b0;
      word_p1_q     <= '0;
      shift_p1_q    <= '0;
      vld_p1_q      <= 1'b0;
      doutb_q       <= '0;
      doutb_valid_q <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      acc_ovf_q     <= acc_ovf_d;
      word_p1_q     <= word_p1_d;
      shift_p1_q    <= shift_p1_d;
      vld_p1_q      <= vld_p1_d;
      doutb_q       <= doutb_d;
      doutb_valid_q <= doutb_valid_d;
    end
  end

  assign doutb       = doutb_q;
  assign doutb_valid = doutb_valid_q;
  assign acc_ovf     = acc_ovf_q;

endmodule

// File: tb/tb_acc_requant_buffer.sv
// Directed testbench for acc_requant_buffer with default parameters
// (20-bit lanes, 8-bit outputs, 16 lanes, 64 entries).
module tb_acc_requant_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wea, acc_en, enb, clr_on_rd, ovf_clr;
  logic [5:0]   addra, addrb;
  logic [319:0] dina;
  logic [4:0]   shift;
  logic [127:0] doutb;
  logic         doutb_valid, acc_ovf;

  int tests = 0;
  int fails = 0;

  logic signed [19:0] ln [16];
  logic signed [7:0]  eo [16];
  logic [127:0]       rw;
  logic               rv;

  always #5 clk = ~clk;

  acc_requant_buffer dut (
    .clk(clk), .rst_n(rst_n), .wea(wea), .acc_en(acc_en), .addra(addra),
    .dina(dina), .enb(enb), .addrb(addrb), .shift(shift),
    .clr_on_rd(clr_on_rd), .ovf_clr(ovf_clr), .doutb(doutb),
    .doutb_valid(doutb_valid), .acc_ovf(acc_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [319:0] pack_in();
    logic [319:0] r;
    for (int i = 0; i < 16; i++) r[i*20 +: 20] = ln[i];
    return r;
  endfunction

  function automatic logic [127:0] pack_out();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[(15-i)*8 +: 8] = eo[i];
    return r;
  endfunction

  task automatic set_ln(input logic signed [19:0] v);
    for (int i = 0; i < 16; i++) ln[i] = v;
  endtask

  task automatic set_eo(input logic signed [7:0] v);
    for (int i = 0; i < 16; i++) eo[i] = v;
  endtask

  task automatic rd(input logic [5:0] a, input logic [4:0] sh, input logic c,
                    output logic [127:0] w, output logic v);
    addrb = a; shift = sh; clr_on_rd = c; enb = 1'b1;
    tick();
    enb = 1'b0; clr_on_rd = 1'b0;
    tick();
    w = doutb; v = doutb_valid;
  endtask

  initial begin
    rst_n = 1'b0; wea = 1'b0; acc_en = 1'b0; enb = 1'b0; clr_on_rd = 1'b0;
    ovf_clr = 1'b0; addra = '0; addrb = '0; dina = '0; shift = '0;
    repeat (3) tick();
    chk("reset_doutb", doutb, 128'd0);
    chk("reset_valid", doutb_valid, 1'b0);
    chk("reset_ovf", acc_ovf, 1'b0);
    rst_n = 1'b1;
    tick();

    // Unwritten entry reads as zero; valid is a single-cycle strobe after two edges
    addrb = 6'd3; shift = 5'd0; enb = 1'b1;
    tick();
    enb = 1'b0;
    chk("rd3_vld_edge1", doutb_valid, 1'b0);
    tick();
    chk("rd3_vld_edge2", doutb_valid, 1'b1);
    chk("rd3_data", doutb, 128'd0);
    tick();
    chk("rd3_vld_drop", doutb_valid, 1'b0);

    // Overwrite lane k = k, then accumulate +10 on two consecutive edges
    for (int k = 0; k < 16; k++) ln[k] = 20'(k);
    wea = 1'b1; acc_en = 1'b0; addra = 6'd5; dina = pack_in();
    tick();
    set_ln(20'sd10);
    acc_en = 1'b1; dina = pack_in();
    tick();
    tick();
    wea = 1'b0; acc_en = 1'b0;
    rd(6'd5, 5'd0, 1'b0, rw, rv);
    for (int k = 0; k < 16; k++) eo[k] = 8'(k + 20);
    chk("acc_vld", rv, 1'b1);
    chk("acc_data", rw, pack_out());
    chk("acc_no_ovf", acc_ovf, 1'b0);

    // Positive saturation sets acc_ovf; shift 31 clamps to 19
    set_ln(20'sd0);
    ln[0] = 20'sd524283;            // 2^19 - 5
    wea = 1'b1; acc_en = 1'b0; addra = 6'd10; dina = pack_in();
    tick();
    ln[0] = 20'sd100;
    acc_en = 1'b1; dina = pack_in();
    tick();
    wea = 1'b0; acc_en = 1'b0;
    chk("ovf_set", acc_ovf, 1'b1);
    rd(6'd10, 5'd31, 1'b0, rw, rv);
    set_eo(8'sd0);
    eo[0] = 8'sd1;                  // (2^19-1 + 2^18) >>> 19 = 1
    chk("sat_shift_clamp", rw, pack_out());
    wea = 1'b1; acc_en = 1'b1; ovf_clr = 1'b1;
    tick();
    chk("ovf_set_beats_clr", acc_ovf, 1'b1);
    wea = 1'b0; acc_en = 1'b0;
    tick();
    chk("ovf_clr", acc_ovf, 1'b0);
    ovf_clr = 1'b0;

    // Requant with shift 4: rounding, negative floor, and output clamps
    set_ln(20'sd0);
    ln[0] = 20'sd24; ln[1] = 20'sd23; ln[2] = -20'sd24;
    ln[3] = -20'sd25; ln[4] = 20'sd5000; ln[5] = -20'sd5000;
    wea = 1'b1; acc_en = 1'b0; addra = 6'd20; dina = pack_in();
    tick();
    wea = 1'b0;
    rd(6'd20, 5'd4, 1'b0, rw, rv);
    set_eo(8'sd0);
    eo[0] = 8'sd2; eo[1] = 8'sd1; eo[2] = -8'sd1;
    eo[3] = -8'sd2; eo[4] = 8'sd127; eo[5] = -8'sd128;
    chk("requant_s4", rw, pack_out());

    // Same-cycle write and read of addr 6 returns the pre-write value
    set_ln(20'sd3);
    wea = 1'b1; addra = 6'd6; dina = pack_in();
    tick();
    set_ln(20'sd7);
    dina = pack_in(); addrb = 6'd6; shift = 5'd0; enb = 1'b1;
    tick();
    wea = 1'b0; enb = 1'b0;
    tick();
    set_eo(8'sd3);
    chk("rw_same_old", doutb, pack_out());

    // Clear-on-read followed back-to-back by a second read
    addrb = 6'd6; clr_on_rd = 1'b1; enb = 1'b1;
    tick();
    clr_on_rd = 1'b0;
    tick();
    enb = 1'b0;
    set_eo(8'sd7);
    chk("clr_first", doutb, pack_out());
    tick();
    chk("clr_second_vld", doutb_valid, 1'b1);
    chk("clr_second", doutb, 128'd0);

    // Write and clear_on_rd to the same address: write keeps the entry valid
    set_ln(20'sd9);
    wea = 1'b1; addra = 6'd6; dina = pack_in();
    addrb = 6'd6; clr_on_rd = 1'b1; enb = 1'b1;
    tick();
    wea = 1'b0; clr_on_rd = 1'b0;
    tick();
    enb = 1'b0;
    chk("wr_clr_prev", doutb, 128'd0);
    tick();
    set_eo(8'sd9);
    chk("wr_clr_wins", doutb, pack_out());

    // Streaming reads of addr 5, then reset mid-stream
    addrb = 6'd5; shift = 5'd0; enb = 1'b1;
    tick();
    tick();
    tick();
    for (int k = 0; k < 16; k++) eo[k] = 8'(k + 20);
    chk("stream_vld", doutb_valid, 1'b1);
    chk("stream_data", doutb, pack_out());
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    enb = 1'b0;
    chk("rst_async_doutb", doutb, 128'd0);
    chk("rst_async_vld", doutb_valid, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("no_vld_after_rst", doutb_valid, 1'b0);
    end
    rd(6'd5, 5'd0, 1'b0, rw, rv);
    chk("post_rst_vld", rv, 1'b1);
    chk("post_rst_data", rw, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
